// File: rtl/mult_acc_pkg.sv
// Shared widths and FSM state type for the multiply-accumulate block.
package mult_acc_pkg;

    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_XW = ACC_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/wallace_multiplier_8bit_by_8bit.sv
// Combinational 8x8 unsigned multiplier: partial-product rows reduced by a
// carry-save (3:2) tree to two rows, then one carry-propagate add.
module wallace_multiplier_8bit_by_8bit
    import mult_acc_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] pp [OP_W];
    logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    // Row-wise 3:2 compressor; bits carried past the MSB are dropped because
    // the final product always fits in PROD_W bits.
    function automatic logic [2*PROD_W-1:0] csa(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    always_comb begin
        for (int i = 0; i < int'(OP_W); i++) begin
            pp[i] = (PROD_W'(a) & {PROD_W{b[i]}}) << i;
        end
        // 8 rows -> 6 -> 4 -> 3 -> 2
        {c0, s0} = csa(pp[0], pp[1], pp[2]);
        {c1, s1} = csa(pp[3], pp[4], pp[5]);
        {c2, s2} = csa(s0, c0, s1);
        {c3, s3} = csa(c1, pp[6], pp[7]);
        {c4, s4} = csa(s2, c2, s3);
        {c5, s5} = csa(s4, c4, c3);
        product  = s5 + c5;
    end

endmodule

// File: rtl/mult_accumulator.sv
// Streaming multiply-accumulate: sums a*b over each in_last-terminated group.
// MULT_ACCUMULATOR_SATURATE_EN: clamp acc at all-ones on overflow (else wrap).
module mult_accumulator
    import mult_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic               prod_v_q, prod_v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [PROD_W-1:0]  mult_p;
    logic [ACC_XW-1:0]  sum;
    logic               in_fire;
    logic               out_fire;

    wallace_multiplier_8bit_by_8bit u_mult (
        .a       (in_a),
        .b       (in_b),
        .product (mult_p)
    );

    always_comb begin
        in_fire     = in_valid & in_ready_q;
        out_fire    = out_valid_q & out_ready;
        sum         = {1'b0, acc_q} + ACC_XW'(prod_q);

        state_d     = state_q;
        prod_d      = prod_q;
        prod_v_d    = in_fire;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;

        if (in_fire) begin
            prod_d = mult_p;
        end

        // Second pipeline stage: fold the registered product into the sum.
        if (prod_v_q) begin
            ovf_d = ovf_q | sum[ACC_W];
`ifdef MULT_ACCUMULATOR_SATURATE_EN
            acc_d = (ovf_q | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        case (state_q)
            ACC: begin
                if (in_fire && in_last) begin
                    state_d = FLUSH;
                end
            end
            // Wait until the last product has been folded in.
            FLUSH: begin
                if (!prod_v_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase

        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule
